pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/riscv_pkg.sv | 13 +
 rtl/pc_fetch_ctrl_plus4.sv | 14 +
 rtl/pc_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end.
package riscv_pkg;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_plus4.sv
// Sequential-PC adder shared by the PC update and the presented pc+4 value.
module PC_Plus_4
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4_c
);

    // Wraps naturally modulo 2^XLEN.
    assign pc_plus4_c = pc + XLEN'(PC_INC);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: request, wait for data,
// hold the word for decode, and follow redirects with a kill on in-flight data.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_plus4_o,
    output logic            misaligned_o
);

    fetch_state_e    state;
    fetch_state_e    state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] pc_plus4;
    logic            kill;
    logic            kill_n;
    logic            latch;
    logic            consume;
    logic            redirect_take;
    logic [XLEN-1:0] redirect_target;

    logic            req_n;
    logic [XLEN-1:0] addr_n;
    logic            valid_n;
    logic [XLEN-1:0] if_pc_n;
    logic [XLEN-1:0] if_instr_n;
    logic [XLEN-1:0] if_plus4_n;
    logic            misaligned_n;

    PC_Plus_4 #(.XLEN(XLEN)) u_pc_plus_4 (
        .pc         (pc),
        .pc_plus4_c (pc_plus4)
    );

    // Redirects are ignored only in the single post-reset IDLE cycle.
    assign redirect_take   = redirect_valid_i && (state != ST_IDLE);
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, next pc and kill tracking.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        kill_n  = kill;
        latch   = 1'b0;
        consume = 1'b0;
        case (state)
            ST_IDLE: begin
                state_n = ST_REQ;
                pc_n    = RESET_VECTOR;
            end
            ST_REQ: begin
                if (redirect_take) begin
                    pc_n = redirect_target;
                end
                // A grant coinciding with a redirect leaves stale data in flight.
                if (imem_gnt_i) begin
                    state_n = ST_WAIT;
                    kill_n  = redirect_take;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    if (redirect_take || kill) begin
                        state_n = ST_REQ;
                        kill_n  = 1'b0;
                        if (redirect_take) begin
                            pc_n = redirect_target;
                        end
                    end else begin
                        state_n = ST_HOLD;
                        latch   = 1'b1;
                    end
                end else if (redirect_take) begin
                    pc_n   = redirect_target;
                    kill_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_take) begin
                    pc_n    = redirect_target;
                    state_n = ST_REQ;
                end else if (!stall_i) begin
                    pc_n    = pc_plus4;
                    state_n = ST_REQ;
                    consume = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        req_n        = (state_n == ST_REQ);
        addr_n       = pc_n;
        valid_n      = if_valid_o;
        if_pc_n      = if_pc_o;
        if_instr_n   = if_instr_o;
        if_plus4_n   = if_pc_plus4_o;
        misaligned_n = redirect_take && (redirect_pc_i[1:0] != 2'b00);
        if (redirect_take || consume) begin
            valid_n = 1'b0;
        end
        if (latch) begin
            valid_n    = 1'b1;
            if_pc_n    = pc;
            if_instr_n = imem_rdata_i;
            if_plus4_n = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc            <= RESET_VECTOR;
            kill          <= 1'b0;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= '0;
            if_valid_o    <= 1'b0;
            if_pc_o       <= '0;
            if_instr_o    <= '0;
            if_pc_plus4_o <= XLEN'(PC_INC);
            misaligned_o  <= 1'b0;
        end else begin
            pc            <= pc_n;
            kill          <= kill_n;
            imem_req_o    <= req_n;
            imem_addr_o   <= addr_n;
            if_valid_o    <= valid_n;
            if_pc_o       <= if_pc_n;
            if_instr_o    <= if_instr_n;
            if_pc_plus4_o <= if_plus4_n;
            misaligned_o  <= misaligned_n;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl with a transaction-level fetch model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_plus4_o;
    logic        misaligned_o;

    pc_fetch_ctrl #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_instr_o       (if_instr_o),
        .if_pc_plus4_o    (if_pc_plus4_o),
        .misaligned_o     (misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] target;
        logic        mis;
    } cyc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
    } pres_t;

    cyc_t  cyc_q[$];
    pres_t exp_q[$];
    int    rise_cyc[$];
    int    checks = 0;
    int    errors = 0;
    int    presented = 0;

    // Fetch model: where the next request must go and what is in flight.
    logic [31:0] target = RV;
    logic [31:0] p_addr = '0;
    logic [31:0] last_pc = '0;
    logic        pending = 1'b0;
    logic        p_live = 1'b0;
    logic        last_rst = 1'b1;
    int          lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; inputs change on the falling edge.
    task automatic drive_cycle(input logic rst, input logic st, input logic rd,
                               input logic [31:0] rp, input int unsigned gnt_pct,
                               input int unsigned lat_min, input int unsigned lat_max,
                               input logic force_rv);
        logic  rd_acc;
        cyc_t  c;
        pres_t e;
        @(negedge clk);
        if (last_rst) begin
            chk("rst_req", 32'(imem_req_o), 32'd0);
            chk("rst_addr", imem_addr_o, 32'd0);
            chk("rst_valid", 32'(if_valid_o), 32'd0);
            chk("rst_pc", if_pc_o, 32'd0);
            chk("rst_instr", if_instr_o, 32'd0);
            chk("rst_plus4", if_pc_plus4_o, 32'd4);
            chk("rst_mis", 32'(misaligned_o), 32'd0);
        end
        if (rst) begin
            rst_n = 1'b0;
            stall_i = 1'b0;
            redirect_valid_i = 1'b0;
            imem_gnt_i = 1'b0;
            imem_rvalid_i = 1'b0;
            pending = 1'b0;
            exp_q.delete();
            target = RV;
            c.target = RV;
            c.mis = 1'b0;
            cyc_q.push_back(c);
            last_rst = 1'b1;
            return;
        end
        rst_n = 1'b1;
        rd_acc = rd && !last_rst;
        stall_i = st;
        redirect_valid_i = rd;
        redirect_pc_i = rp;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = $urandom;
        if (pending) begin
            if (lat == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i = p_live ? mem_word(p_addr) : 32'hDEAD_BEEF;
                if (p_live && !rd_acc) begin
                    e.pc = p_addr;
                    e.instr = mem_word(p_addr);
                    e.plus4 = p_addr + 32'd4;
                    exp_q.push_back(e);
                    last_pc = p_addr;
                end
                pending = 1'b0;
            end else begin
                lat--;
            end
        end else if (force_rv) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
        end
        imem_gnt_i = 1'b0;
        if (!pending && imem_req_o && ($urandom_range(99, 0) < gnt_pct)) begin
            imem_gnt_i = 1'b1;
            pending = 1'b1;
            p_addr = target;
            p_live = !rd_acc;
            lat = int'($urandom_range(lat_max, lat_min));
        end
        if (rd_acc) begin
            target = {rp[31:2], 2'b00};
            if (pending) p_live = 1'b0;
        end else if (if_valid_o && !st) begin
            target = last_pc + 32'd4;
        end
        c.target = target;
        c.mis = rd_acc && (rp[1:0] != 2'b00);
        cyc_q.push_back(c);
        last_rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 0, 0, 1'b0);
    endtask

    // Run until a grant is issued this cycle, with a fixed response latency.
    task automatic until_grant(input int unsigned l, input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, l, l, 1'b0);
            if (imem_gnt_i) break;
        end
        if (k == 30) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_grant required=grant", name);
        end
    endtask

    // Monitor: checks everything the DUT shows, just after each rising edge.
    int    mcyc = 0;
    logic  prev_valid = 1'b0;
    logic  have_cur = 1'b0;
    pres_t cur;
    always @(posedge clk) begin
        cyc_t c;
        #1;
        mcyc++;
        if (cyc_q.size() != 0) begin
            c = cyc_q.pop_front();
            chk("misaligned", 32'(misaligned_o), 32'(c.mis));
            if (imem_req_o) chk("req_addr", imem_addr_o, c.target);
            chk("req_while_valid", 32'(imem_req_o && if_valid_o), 32'd0);
            if (if_valid_o === 1'b1 && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 1'b0;
                    $display("FAIL present_unexpected actual_pc=%h actual_instr=%h required=none",
                             if_pc_o, if_instr_o);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    presented++;
                    rise_cyc.push_back(mcyc);
                end
            end
            if (if_valid_o === 1'b1 && have_cur) begin
                chk("if_pc", if_pc_o, cur.pc);
                chk("if_instr", if_instr_o, cur.instr);
                chk("if_plus4", if_pc_plus4_o, cur.plus4);
            end
            prev_valid = (if_valid_o === 1'b1);
        end
    end

    initial begin
        logic [31:0] rp;
        int          k;
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 0, 0, 0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 0, 0, 0, 1'b0);

        // Zero-latency streaming from the reset vector.
        rise_cyc.delete();
        idle_cycles(14);
        chk("tput_count", 32'(rise_cyc.size() >= 3), 32'd1);
        if (rise_cyc.size() >= 3) begin
            chk("tput_gap0", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
            chk("tput_gap1", 32'(rise_cyc[2] - rise_cyc[1]), 32'd3);
        end

        // Decode stalls for five cycles while an instruction is held.
        for (k = 0; k < 20; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 32'd0, 100, 0, 0, 1'b0);
            if (if_valid_o) break;
        end
        chk("stall_reach_hold", 32'(if_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 32'd0, 100, 0, 0, 1'b0);
        idle_cycles(6);

        // Redirect during WAIT; stale data arrives two cycles later.
        until_grant(2, "kill");
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_2000, 100, 0, 0, 1'b0);
        idle_cycles(10);

        // Misaligned redirect target.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_3002, 100, 0, 0, 1'b0);
        idle_cycles(8);

        // Top-of-address-space wrap.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 100, 0, 0, 1'b0);
        idle_cycles(10);

        // Reset pulse while waiting for data; stray rvalid in IDLE.
        until_grant(3, "rst_wait");
        drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 0, 0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 0, 0, 0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 100, 0, 0, 1'b1);
        idle_cycles(8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(3, 0))
                0:       rp = ($urandom_range(1, 0) == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
                1:       rp = $urandom;
                default: rp = 32'h0000_4000 + 32'($urandom_range(255, 0));
            endcase
            drive_cycle($urandom_range(999, 0) < 3, $urandom_range(99, 0) < 35,
                        $urandom_range(99, 0) < 6, rp, 60, 0, 3, 1'b0);
        end

        for (k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && !pending) break;
            idle_cycles(1);
        end
        idle_cycles(3);
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("liveness", 32'(presented > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
